// File: rtl/rf_pkg.sv
// Shared types and constants for the parametrised register file.
package rf_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DW_DEFAULT = 32;
  localparam int RF_AW_DEFAULT = 5;

  localparam int RF_INIT_ZERO  = 0;
  localparam int RF_INIT_INDEX = 1;

endpackage

// File: rtl/rf_init_seq.sv
// Init walk sequencer: after reset, steps through registers 1..NREG-1 loading
// the init pattern, then parks in READY until the next reset.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int DW        = RF_DW_DEFAULT,
  parameter int AW        = RF_AW_DEFAULT,
  parameter int INIT_MODE = RF_INIT_INDEX
) (
  input  logic          clk,
  input  logic          clr,
  output logic          init_busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic [DW-1:0] init_data
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AW{1'b1}}) begin
        state_d = RF_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RF_INIT;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr suppresses the init write so the array is untouched during reset.
  always_comb begin
    init_busy = (state_q == RF_INIT);
    init_we   = init_busy && !clr;
    init_addr = cnt_q;
    init_data = '0;
    if (INIT_MODE == RF_INIT_INDEX) begin
      init_data[AW-1:0] = cnt_q;
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised 2R1W register file with optional write bypass, registered
// debug tap and a post-reset init walk.
module param_regfile
  import rf_pkg::*;
#(
  parameter int DW        = RF_DW_DEFAULT,
  parameter int AW        = RF_AW_DEFAULT,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = RF_INIT_INDEX
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic          we,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] d,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_q,
  output logic          init_busy
);

  localparam int NREG = 2 ** AW;

  if (DW < AW) begin : g_width_check
    $error("param_regfile: DW must be >= AW");
  end

  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;

  rf_init_seq #(
    .DW        (DW),
    .AW        (AW),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .clk       (clk),
    .clr       (clr),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  logic [DW-1:0] mem_q [NREG];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ext_wr;
  logic [DW-1:0] dbg_tap_q, dbg_tap_d;

  // External writes only land in READY, outside reset, and never on r0.
  always_comb begin
    ext_wr  = !init_busy && !clr && we && (wn != '0);
    wr_en   = 1'b0;
    wr_addr = wn;
    wr_data = d;
    if (init_we) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_data = init_data;
    end else if (ext_wr) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Forwarding uses the raw write request so it is visible before the edge.
  always_comb begin
    qa = '0;
    qb = '0;
    if (!init_busy && (rna != '0)) begin
      if ((BYPASS != 0) && we && (wn != '0) && (wn == rna)) qa = d;
      else                                                   qa = mem_q[rna];
    end
    if (!init_busy && (rnb != '0)) begin
      if ((BYPASS != 0) && we && (wn != '0) && (wn == rnb)) qb = d;
      else                                                   qb = mem_q[rnb];
    end
  end

  always_comb begin
    dbg_tap_d = '0;
    if (!init_busy && (dbg_sel != '0)) begin
      dbg_tap_d = mem_q[dbg_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) dbg_tap_q <= '0;
    else     dbg_tap_q <= dbg_tap_d;
  end

  assign dbg_q = dbg_tap_q;

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: one bypassing and one non-bypassing
// instance driven by the same stimulus.
module tb_param_regfile;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  rna, rnb, wn, dbg_sel;
  logic        we;
  logic [31:0] d;
  logic [31:0] qa1, qb1, dbg1, qa0, qb0, dbg0;
  logic        busy1, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_regfile #(.DW(32), .AW(5), .BYPASS(1), .INIT_MODE(1)) u_byp (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
    .we(we), .wn(wn), .d(d), .dbg_sel(dbg_sel), .dbg_q(dbg1), .init_busy(busy1)
  );

  param_regfile #(.DW(32), .AW(5), .BYPASS(0), .INIT_MODE(1)) u_nob (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
    .we(we), .wn(wn), .d(d), .dbg_sel(dbg_sel), .dbg_q(dbg0), .init_busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;
  logic qa_zero;

  initial begin
    clr = 1'b1; rna = 5'd9; rnb = 5'd31; we = 1'b1; wn = 5'd3;
    d = 32'hFFFF_FFFF; dbg_sel = 5'd9;
    tick();
    tick();
    chk("reset_busy", {31'd0, busy1}, 32'd1);
    chk("reset_dbg", dbg1, 32'd0);
    chk("reset_qa", qa1, 32'd0);

    // First walk: writes to r3 are held the whole time and must be ignored.
    clr = 1'b0;
    n = 0; qa_zero = 1'b1;
    while (busy1 && n < 100) begin
      if (qa1 !== 32'd0 || qa0 !== 32'd0) qa_zero = 1'b0;
      tick();
      n++;
    end
    chk("init_edges", n, 32'd31);
    chk("init_qa_zero", {31'd0, qa_zero}, 32'd1);
    chk("init_busy_nob", {31'd0, busy0}, 32'd0);
    chk("init_dbg_zero", dbg1, 32'd0);
    we = 1'b0;
    #1;
    chk("read_r9", qa1, 32'h0000_0009);
    chk("read_r31", qb1, 32'h0000_001F);
    rna = 5'd3;
    #1;
    chk("init_blocked_r3", qa1, 32'h0000_0003);

    tick();
    chk("dbg_r9", dbg1, 32'h0000_0009);
    we = 1'b1; wn = 5'd9; d = 32'h0000_0055;
    tick();
    chk("dbg_same_edge_old", dbg1, 32'h0000_0009);
    we = 1'b0;
    tick();
    chk("dbg_new", dbg1, 32'h0000_0055);

    we = 1'b1; wn = 5'd4; d = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; rna = 5'd4;
    #1;
    chk("wr_rd_r4", qa1, 32'hDEAD_BEEF);
    chk("wr_rd_r4_nob", qa0, 32'hDEAD_BEEF);

    we = 1'b1; wn = 5'd0; d = 32'h0000_1234; rna = 5'd0; dbg_sel = 5'd0;
    #1;
    chk("r0_no_bypass", qa1, 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("r0_after_write", qa1, 32'd0);
    chk("dbg_r0", dbg1, 32'd0);

    we = 1'b1; wn = 5'd7; d = 32'h1234_5678; rna = 5'd7; rnb = 5'd7;
    #1;
    chk("byp_qa", qa1, 32'h1234_5678);
    chk("byp_qb", qb1, 32'h1234_5678);
    chk("nobyp_qa_pre", qa0, 32'h0000_0007);
    chk("nobyp_qb_pre", qb0, 32'h0000_0007);
    tick();
    we = 1'b0;
    #1;
    chk("nobyp_qa_post", qa0, 32'h1234_5678);
    chk("byp_qa_post", qa1, 32'h1234_5678);

    we = 1'b1; wn = 5'd5; d = 32'h0000_00AA;
    tick();
    we = 1'b0; rna = 5'd5;
    #1;
    chk("r5_aa", qa1, 32'h0000_00AA);

    // Restart the walk partway through: reset, 9 init edges, reset on edge 10.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_init_busy", {31'd0, busy1}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      tick();
      n++;
    end
    chk("reinit_edges", n, 32'd31);
    rna = 5'd5; rnb = 5'd7;
    #1;
    chk("reinit_r5", qa1, 32'h0000_0005);
    chk("reinit_r7", qb1, 32'h0000_0007);
    rna = 5'd4; rnb = 5'd9;
    #1;
    chk("reinit_r4", qa0, 32'h0000_0004);
    chk("reinit_r9", qb0, 32'h0000_0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised general-purpose register file for the pipelined CPU. It is the successor to the fixed 32x32 file.
- Configurable data width and register count, with two combinational read ports and one write port.
- Optional write-to-read bypass for same-cycle forwarding.
- Registered debug tap replaces the hard-wired r9 output.
- Reset starts a sequential init walk that loads each register with a programmable pattern. The file reports busy until the walk completes.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; register count NREG = 2**AW. Register 0 is hard-wired zero.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
- INIT_MODE, 1, init value selector: 0 = all zero; 1 = register index, zero-extended to DW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- rna  in  AW  read address, port A.
- rnb  in  AW  read address, port B.
- qa  out  DW  read data, port A (combinational).
- qb  out  DW  read data, port B (combinational).
- we  in  1  write enable.
- wn  in  AW  write address.
- d  in  DW  write data.
- dbg_sel  in  AW  debug tap address.
- dbg_q  out  DW  debug tap data, registered.
- init_busy  out  1  high while the init walk is in progress.

Behaviour:
- Reset:
  - The design has one clock, clk. Reset clr is synchronous and active-high.
  - While clr=1 at a rising edge: FSM goes to INIT, init counter goes to 1, dbg_q goes to 0.
  - No register array writes occur while clr=1.
  - init_busy=1 throughout reset.
- FSM states and transitions:
  - INIT, on each edge with clr=0: write init value to reg[cnt], then cnt <= cnt+1.
  - When cnt = NREG-1, that edge performs the last write and moves to READY.
  - Init therefore takes exactly NREG-1 edges after clr falls (31 edges for AW=5).
  - READY: stays until clr=1.
  - clr=1 mid-INIT or in READY returns to INIT with cnt=1; the walk restarts from the beginning.
- init_busy:
  - Equals 1 in INIT and 0 in READY.
  - Derived from state only; no extra cycle of latency.
- Reads, register 0 and busy:
  - qa = 0 when rna = 0 or init_busy = 1. Likewise qb with rnb.
  - Otherwise the read returns reg[addr].
- Bypass:
  - Applies when BYPASS=1, state is READY, we=1, wn!=0 and wn equals the read address.
  - In that case the read port returns d in the same cycle.
  - Both ports can bypass simultaneously.
  - With BYPASS=0 the read returns the old value until the next edge.
- Writes:
  - In READY, at a rising edge with we=1 and wn!=0: reg[wn] <= d.
  - wn=0 is ignored.
  - we is ignored in INIT, with no error flag.
- Debug tap:
  - In READY: dbg_q <= reg[dbg_sel] each edge, using the pre-edge array contents (no bypass), and 0 when dbg_sel=0.
  - In INIT: dbg_q <= 0.
  - Latency is 1 cycle.
- Width rules:
  - INIT_MODE=1 value is cnt zero-extended to DW.
  - DW must be >= AW; this is an elaboration-time check.
- Simultaneous events:
  - clr has priority over the write and the init step.
  - A write and a dbg_sel to the same address in the same cycle gives the old value at dbg_q.

Decomposition:
- Shared package rf_pkg:
  - State enum {RF_INIT, RF_READY}.
  - Default DW/AW constants.
  - INIT_MODE encodings RF_INIT_ZERO=0 and RF_INIT_INDEX=1.
- Sub-module rf_init_seq:
  - Owns the FSM and counter.
  - Outputs init_busy, init_we, init_addr, init_data.
- The top level:
  - Muxes init_* against the external write port.
  - Holds the array, read/bypass logic and debug register.

Test Plan:
- Reset and init walk, AW=5, INIT_MODE=1:
  - Stimulus: clr=1 for 2 edges, then 0.
  - Response: init_busy is 1 for exactly 31 edges after clr falls. qa=0 throughout. Afterwards rna=9 gives qa=32'h00000009 and rnb=31 gives qb=32'h0000001F.
- Write and read-back:
  - Stimulus: in READY, we=1, wn=4, d=32'hDEADBEEF for one edge; then rna=4.
  - Response: qa=32'hDEADBEEF. A write to wn=0 leaves qa=0 for rna=0.
- Bypass, BYPASS=1:
  - Stimulus: in the same cycle we=1, wn=7, d=32'h12345678 with rna=rnb=7.
  - Response: qa=qb=32'h12345678 before the edge.
  - Rerun with BYPASS=0: qa=32'h00000007 before the edge and 32'h12345678 after.
- Reset mid-init:
  - Stimulus: clr pulsed high at init edge 10 after reg[5] has been written 32'hAA via a prior READY write.
  - Response: the walk restarts, init_busy lasts 31 edges after the second clr falls, and reg[5] = 5 afterwards.
- Writes blocked during init:
  - Stimulus: we=1, wn=3, d=32'hFFFFFFFF held during INIT.
  - Response: after READY, rna=3 gives 32'h00000003.
- Debug tap:
  - Stimulus: dbg_sel=9 in READY.
  - Response: dbg_q=32'h00000009 one edge later.
  - Same-edge write wn=9, d=32'h55: dbg_q shows 9 on that edge and 32'h55 on the next.
